// File: rtl/if_fetch_unit_if.sv
// Byte-wide memory read bus between the fetch unit and memory.
// The master drives the address and the read request; the slave returns data and ready.
interface if_fetch_unit_if;
    logic [15:0] mem_address;
    logic        mem_read;
    logic [7:0]  mem_data_in;
    logic        mem_ready;

    modport master (
        output mem_address,
        output mem_read,
        input  mem_data_in,
        input  mem_ready
    );

    modport slave (
        input  mem_address,
        input  mem_read,
        output mem_data_in,
        output mem_ready
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch: reads three bytes at pc, presents the 24-bit word to decode,
// and holds it until decode finishes, then reloads pc from decode and fetches again.
module if_fetch_unit #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   halt,
    if_fetch_unit_if.master        mem,
    output logic [23:0]            instruction,
    output logic                   execute,
    output logic [15:0]            current_instruction_address,
    input  logic [15:0]            next_instruction_address,
    input  logic                   instruction_finished,
    output logic                   busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_F0,
        S_F1,
        S_F2,
        S_EXEC
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [23:0] instr_q, instr_d;
    logic        exec_q, exec_d;
    logic        rd;
    logic [15:0] addr;
    logic [15:0] pc_p1;
    logic [15:0] pc_p2;

    assign pc_p1 = pc_q + 16'd1;
    assign pc_p2 = pc_q + 16'd2;

    // Next-state, byte capture and bus request for the fetch sequence.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        rd      = 1'b0;
        addr    = pc_q;
        unique case (state_q)
            S_IDLE: begin
                if (!halt) state_d = S_F0;
            end
            S_F0: begin
                rd   = 1'b1;
                addr = pc_q;
                if (mem.mem_ready) begin
                    instr_d[23:16] = mem.mem_data_in;
                    state_d        = S_F1;
                end
            end
            S_F1: begin
                rd   = 1'b1;
                addr = pc_p1;
                if (mem.mem_ready) begin
                    instr_d[15:8] = mem.mem_data_in;
                    state_d       = S_F2;
                end
            end
            S_F2: begin
                rd   = 1'b1;
                addr = pc_p2;
                if (mem.mem_ready) begin
                    instr_d[7:0] = mem.mem_data_in;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                if (instruction_finished) begin
                    pc_d    = next_instruction_address;
                    state_d = halt ? S_IDLE : S_F0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        exec_d = (state_d == S_EXEC);
    end

    // State, pc and output registers; reset abandons any fetch or execution.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_VECTOR;
            instr_q <= 24'h000000;
            exec_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            exec_q  <= exec_d;
        end
    end

    assign mem.mem_read                = rd;
    assign mem.mem_address             = addr;
    assign instruction                 = instr_q;
    assign execute                     = exec_q;
    assign current_instruction_address = pc_q;
    assign busy                        = (state_q != S_IDLE);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: the bench plays memory and decode, and a per-instruction
// procedural model predicts bus addresses, the assembled word and pc updates.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        halt;
    logic [23:0] instruction;
    logic        execute;
    logic [15:0] cia;
    logic [15:0] next_addr;
    logic        finished;
    logic        busy;

    logic [23:0] w_instruction;
    logic        w_execute;
    logic [15:0] w_cia;
    logic        w_busy;

    logic [7:0]  mem [0:65535];
    logic [15:0] m_pc;
    logic [23:0] m_instr;
    int          n_checks = 0;
    int          n_fail   = 0;

    if_fetch_unit_if bus ();
    if_fetch_unit_if wbus ();

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk                         (clk),
        .reset                       (reset),
        .halt                        (halt),
        .mem                         (bus.master),
        .instruction                 (instruction),
        .execute                     (execute),
        .current_instruction_address (cia),
        .next_instruction_address    (next_addr),
        .instruction_finished        (finished),
        .busy                        (busy)
    );

    assign wbus.mem_ready   = 1'b1;
    assign wbus.mem_data_in = mem[wbus.mem_address];

    if_fetch_unit #(.RESET_VECTOR(16'hFFFE)) u_wrap (
        .clk                         (clk),
        .reset                       (reset),
        .halt                        (1'b0),
        .mem                         (wbus.master),
        .instruction                 (w_instruction),
        .execute                     (w_execute),
        .current_instruction_address (w_cia),
        .next_instruction_address    (16'h0000),
        .instruction_finished        (1'b0),
        .busy                        (w_busy)
    );

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at the negedge after a reset edge, with reset still high.
    task automatic reset_check();
        chk("rst_execute", {23'd0, execute}, 24'd0);
        chk("rst_mem_read", {23'd0, bus.mem_read}, 24'd0);
        chk("rst_pc", {8'd0, cia}, 24'd0);
        chk("rst_addr", {8'd0, bus.mem_address}, 24'd0);
        chk("rst_instr", instruction, 24'd0);
        chk("rst_busy", {23'd0, busy}, 24'd0);
        m_pc    = 16'h0000;
        m_instr = 24'h000000;
        reset   = 1'b0;
        halt    = 1'b0;
        bus.mem_ready = 1'b0;
        finished = 1'b0;
        @(negedge clk);
    endtask

    // Starts at a negedge with the unit expected in its first fetch cycle.
    // abort: 0 none, 1 reset during the third byte, 2 reset during execution.
    task automatic fetch_one(input int w0, input int w1, input int w2, input int hold,
                             input logic [15:0] nxt, input bit halt_exit, input int abort);
        int          w;
        logic [15:0] a;
        for (int k = 0; k < 3; k++) begin
            w = (k == 0) ? w0 : (k == 1) ? w1 : w2;
            a = m_pc + 16'(k);
            for (int i = 0; i <= w; i++) begin
                chk("f_read", {23'd0, bus.mem_read}, 24'd1);
                chk("f_addr", {8'd0, bus.mem_address}, {8'd0, a});
                chk("f_exec", {23'd0, execute}, 24'd0);
                chk("f_instr", instruction, m_instr);
                chk("f_busy", {23'd0, busy}, 24'd1);
                chk("f_pc", {8'd0, cia}, {8'd0, m_pc});
                halt     = 1'($urandom);
                finished = 1'($urandom);
                next_addr = 16'($urandom);
                if (abort == 1 && k == 2) begin
                    reset = 1'b1;
                    bus.mem_ready = 1'b1;
                    bus.mem_data_in = mem[a];
                    @(negedge clk);
                    reset_check();
                    return;
                end
                if (i == w) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_data_in = mem[a];
                    m_instr[23 - 8*k -: 8] = mem[a];
                end else begin
                    bus.mem_ready = 1'b0;
                    bus.mem_data_in = 8'($urandom);
                end
                @(negedge clk);
            end
        end
        for (int h = 0; h <= hold; h++) begin
            chk("x_exec", {23'd0, execute}, 24'd1);
            chk("x_instr", instruction, m_instr);
            chk("x_read", {23'd0, bus.mem_read}, 24'd0);
            chk("x_pc", {8'd0, cia}, {8'd0, m_pc});
            chk("x_busy", {23'd0, busy}, 24'd1);
            bus.mem_ready = 1'($urandom);
            bus.mem_data_in = 8'($urandom);
            if (abort == 2) begin
                reset = 1'b1;
                finished = 1'b1;
                next_addr = 16'($urandom);
                @(negedge clk);
                reset_check();
                return;
            end
            finished  = (h == hold);
            next_addr = (h == hold) ? nxt : 16'($urandom);
            halt      = (h == hold) ? halt_exit : 1'($urandom);
            @(negedge clk);
        end
        m_pc = nxt;
        finished = 1'b0;
        bus.mem_ready = 1'b0;
        if (halt_exit) begin
            int n_idle = $urandom_range(1, 3);
            for (int i = 0; i < n_idle; i++) begin
                chk("i_busy", {23'd0, busy}, 24'd0);
                chk("i_read", {23'd0, bus.mem_read}, 24'd0);
                chk("i_exec", {23'd0, execute}, 24'd0);
                chk("i_pc", {8'd0, cia}, {8'd0, m_pc});
                bus.mem_ready = 1'($urandom);
                halt = (i != n_idle - 1);
                @(negedge clk);
            end
        end
        halt = 1'b0;
    endtask

    initial begin
        logic [15:0] nx;
        int          ab;
        reset = 1'b1;
        halt = 1'b1;
        finished = 1'b0;
        next_addr = 16'h0000;
        bus.mem_ready = 1'b0;
        bus.mem_data_in = 8'h00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h80;
        mem[1] = 8'h12;
        mem[2] = 8'h34;
        m_pc = 16'h0000;
        m_instr = 24'h000000;
        repeat (2) @(negedge clk);
        chk("r_exec", {23'd0, execute}, 24'd0);
        chk("r_read", {23'd0, bus.mem_read}, 24'd0);
        chk("r_addr", {8'd0, bus.mem_address}, 24'd0);
        chk("r_instr", instruction, 24'd0);
        chk("r_pc", {8'd0, cia}, 24'd0);
        chk("r_busy", {23'd0, busy}, 24'd0);
        chk("w_rst_addr", {8'd0, wbus.mem_address}, 24'h00FFFE);
        chk("w_rst_busy", {23'd0, w_busy}, 24'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("halt_idle_busy", {23'd0, busy}, 24'd0);
        chk("w_a0", {8'd0, wbus.mem_address}, 24'h00FFFE);
        chk("w_rd0", {23'd0, wbus.mem_read}, 24'd1);
        @(negedge clk);
        chk("halt_idle_read", {23'd0, bus.mem_read}, 24'd0);
        chk("w_a1", {8'd0, wbus.mem_address}, 24'h00FFFF);
        @(negedge clk);
        chk("w_a2", {8'd0, wbus.mem_address}, 24'h000000);
        @(negedge clk);
        chk("w_exec", {23'd0, w_execute}, 24'd1);
        chk("w_instr", w_instruction, {mem[16'hFFFE], mem[16'hFFFF], mem[0]});
        halt = 1'b0;
        @(negedge clk);
        fetch_one(0, 0, 0, 0, 16'h0003, 1'b0, 0);
        chk("seq_word", instruction, 24'h801234);
        chk("seq_next_addr", {8'd0, bus.mem_address}, 24'h000003);
        fetch_one(2, 2, 2, 0, 16'h0100, 1'b0, 0);
        fetch_one(0, 1, 0, 3, 16'h1234, 1'b0, 0);
        chk("jump_addr", {8'd0, bus.mem_address}, 24'h001234);
        chk("jump_pc", {8'd0, cia}, 24'h001234);
        fetch_one(0, 0, 0, 0, 16'hFFFE, 1'b0, 0);
        fetch_one(1, 0, 1, 1, 16'h0000, 1'b1, 0);
        fetch_one(0, 0, 0, 0, 16'h0040, 1'b0, 1);
        fetch_one(0, 0, 0, 0, 16'h0040, 1'b0, 2);
        for (int t = 0; t < 60; t++) begin
            nx = 16'($urandom);
            if ($urandom_range(0, 3) == 0) nx = 16'hFFFE + 16'($urandom_range(0, 2));
            ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
            fetch_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 4), nx, ($urandom_range(0, 3) == 0), ab);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
